// File: rtl/cla_pipe.sv
// -----------------------------------------------------------------------------
// cla_pipe -- pipelined carry-lookahead adder/subtractor
//
// A WIDTH-bit add/subtract is split into NSTAGE = WIDTH/SEG segments. Stage k
// resolves segment k with a SEG-bit lookahead adder, using the carry registered
// by stage k-1. Already-resolved low sum segments and the still-unresolved
// operands travel down the pipe with the carry. The last stage register is the
// output register. One operation per cycle; valid/ready handshake on both sides.
//
// Parameters:
//   WIDTH  operand/sum width (multiple of SEG)
//   SEG    segment width resolved per stage
//
// Ports:
//   clk, reset_n          clock (rising edge), async active-low reset
//   in_valid / in_ready   input handshake
//   a, b, ci, sub         operands; sub=1 computes a + ~b + 1 (ci ignored)
//   out_valid / out_ready output handshake
//   s, co                 sum/difference mod 2^WIDTH, carry out (1 = no borrow)
//   ovf                   signed overflow (only with CLA_PIPE_OVF_EN defined)
//
// Optional feature macro: CLA_PIPE_OVF_EN adds the ovf output.
// -----------------------------------------------------------------------------
module cla_pipe #(
    parameter int WIDTH = 64,
    parameter int SEG   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
`ifdef CLA_PIPE_OVF_EN
    output logic             co,
    output logic             ovf
`else
    output logic             co
`endif
);

    localparam int NSTAGE = WIDTH / SEG;
    // Operand registers are only needed by stages that still have a
    // downstream stage to feed; the last stage keeps only sum and carry.
    localparam int OPS    = (NSTAGE > 1) ? NSTAGE - 1 : 1;

    // SEG-bit lookahead adder: returns {carry_out, sum}.
    function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] x,
                                             input logic [SEG-1:0] y,
                                             input logic           cin);
        logic [SEG-1:0] g;
        logic [SEG-1:0] p;
        logic [SEG:0]   c;
        g    = x & y;
        p    = x ^ y;
        c[0] = cin;
        for (int i = 0; i < SEG; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        return {c[SEG], p ^ c[SEG-1:0]};
    endfunction

    logic [NSTAGE-1:0]             v_q, v_d;
    logic [NSTAGE-1:0][WIDTH-1:0]  s_q, s_d;
    logic [NSTAGE-1:0]             c_q, c_d;
    logic [OPS-1:0][WIDTH-1:0]     a_q, a_d;
    logic [OPS-1:0][WIDTH-1:0]     b_q, b_d;

    // What each stage would load: stage 0 from the input port, others from
    // the previous stage register.
    logic [NSTAGE-1:0]             src_v;
    logic [NSTAGE-1:0][WIDTH-1:0]  src_a, src_b, src_s;
    logic [NSTAGE-1:0]             src_c;
    logic [NSTAGE-1:0][SEG:0]      seg_r;
    logic [NSTAGE-1:0]             en;

    // Stage k may load when it, or any stage below it, has a free slot, or
    // the consumer is taking the output this cycle. Closed form of the
    // "empty or advancing" chain, so no combinational self-loop on en.
    always_comb begin : ld_en
        logic full_tail;
        full_tail = 1'b1;
        en        = '0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            full_tail = full_tail & v_q[k];
            en[k]     = out_ready | ~full_tail;
        end
    end

    always_comb begin : src_sel
        src_v[0] = in_valid;
        src_a[0] = a;
        src_b[0] = sub ? ~b : b;
        src_s[0] = '0;
        src_c[0] = sub | ci;
        for (int k = 1; k < NSTAGE; k++) begin
            src_v[k] = v_q[k-1];
            src_a[k] = a_q[k-1];
            src_b[k] = b_q[k-1];
            src_s[k] = s_q[k-1];
            src_c[k] = c_q[k-1];
        end
        for (int k = 0; k < NSTAGE; k++) begin
            seg_r[k] = seg_add(src_a[k][k*SEG +: SEG], src_b[k][k*SEG +: SEG], src_c[k]);
        end
    end

    always_comb begin : nxt
        v_d = v_q;
        s_d = s_q;
        c_d = c_q;
        a_d = a_q;
        b_d = b_q;
        for (int k = 0; k < NSTAGE; k++) begin
            if (en[k]) begin
                v_d[k] = src_v[k];
                // Data only moves with a valid beat so a stalled or empty
                // slot keeps its last contents.
                if (src_v[k]) begin
                    s_d[k]                 = src_s[k];
                    s_d[k][k*SEG +: SEG]   = seg_r[k][SEG-1:0];
                    c_d[k]                 = seg_r[k][SEG];
                end
            end
        end
        for (int k = 0; k < NSTAGE - 1; k++) begin
            if (en[k] && src_v[k]) begin
                a_d[k] = src_a[k];
                b_d[k] = src_b[k];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_q <= '0;
            s_q <= '0;
            c_q <= '0;
            a_q <= '0;
            b_q <= '0;
        end else begin
            v_q <= v_d;
            s_q <= s_d;
            c_q <= c_d;
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign in_ready  = en[0];
    assign out_valid = v_q[NSTAGE-1];
    assign s         = s_q[NSTAGE-1];
    assign co        = c_q[NSTAGE-1];

`ifdef CLA_PIPE_OVF_EN
    // Carry into the MSB recovered from the MSB sum bit and its operands,
    // then compared with the carry out of the MSB.
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (en[NSTAGE-1] && src_v[NSTAGE-1]) begin
            ovf_d = src_a[NSTAGE-1][WIDTH-1] ^ src_b[NSTAGE-1][WIDTH-1]
                  ^ seg_r[NSTAGE-1][SEG-1]   ^ seg_r[NSTAGE-1][SEG];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ovf_q <= 1'b0;
        else          ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_cla_pipe.sv
// -----------------------------------------------------------------------------
// tb_cla_pipe -- self-checking bench for cla_pipe (WIDTH=64, SEG=16).
// Expected results are pushed to a scoreboard queue at accept and popped when
// the DUT transfers a result. Inputs change on the falling edge; everything is
// sampled 1 time unit later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_cla_pipe;

    localparam int W   = 64;
    localparam int SG  = 16;
    localparam int NST = W / SG;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid, in_ready;
    logic [W-1:0]  a, b;
    logic          ci, sub;
    logic          out_valid, out_ready;
    logic [W-1:0]  s;
    logic          co;
`ifdef CLA_PIPE_OVF_EN
    logic          ovf;
`endif

    always #5 clk = ~clk;

    cla_pipe #(.WIDTH(W), .SEG(SG)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
`ifdef CLA_PIPE_OVF_EN
        .co        (co),
        .ovf       (ovf)
`else
        .co        (co)
`endif
    );

    typedef struct packed {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   acc_seen;
    bit   ov_seen;
    int   out_cnt  = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                   input logic ici, input logic isub);
        exp_t         e;
        logic [W-1:0] be;
        logic [W:0]   r;
        be   = isub ? ~ib : ib;
        r    = {1'b0, ia} + {1'b0, be} + {{W{1'b0}}, (isub ? 1'b1 : ici)};
        e.s  = r[W-1:0];
        e.co = r[W];
        e.ov = (ia[W-1] == be[W-1]) && (r[W-1] != ia[W-1]);
        return e;
    endfunction

    // One cycle: drive at falling edge, sample 1 unit later, score, wait.
    task automatic step(input bit iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input bit ici, input bit isub, input bit ordy);
        exp_t e;
        in_valid  = iv;
        a         = ia;
        b         = ib;
        ci        = ici;
        sub       = isub;
        out_ready = ordy;
        #1;
        acc_seen = in_valid && in_ready;
        ov_seen  = out_valid;
        if (acc_seen) exp_q.push_back(model(ia, ib, ici, isub));
        if (out_valid && out_ready) begin
            out_cnt++;
            if (exp_q.size() == 0) begin
                chk("stale_out", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sum", s, e.s);
                chk("co", {63'd0, co}, {63'd0, e.co});
`ifdef CLA_PIPE_OVF_EN
                chk("ovf", {63'd0, ovf}, {63'd0, e.ov});
`endif
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic send(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input bit ici, input bit isub);
        for (int t = 0; t < 50; t++) begin
            step(1'b1, ia, ib, ici, isub, 1'b1);
            if (acc_seen) return;
        end
        chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        for (int t = 0; t < 50 && exp_q.size() > 0; t++) idle();
        chk("drain_left", exp_q.size(), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] bp_a [6];
        logic [W-1:0] bp_b [6];
        logic [W-1:0] held_s;
        logic         held_co;
        int           lat, idx, outs;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        ci        = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_s", s, 64'd0);
        chk("rst_co", {63'd0, co}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Full carry ripple through all segments, and its latency.
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            idle();
            if (ov_seen) break;
            lat++;
        end
        chk("latency", lat, NST - 1);
        drain();

        // Wrap-around without carry-in.
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 1'b0);
        drain();

        // Back-to-back random traffic, adds and subtracts mixed.
        out_cnt = 0;
        idx     = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b1, {$urandom, $urandom}, {$urandom, $urandom},
                 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1);
            if (acc_seen) idx++;
        end
        chk("b2b_accepts", idx, 100);
        chk("b2b_outs_in_stream", out_cnt, 100 - NST);
        drain();
        chk("b2b_outs_total", out_cnt, 100);

        // Backpressure: pipe holds NST beats, then stalls with stable output.
        for (int i = 0; i < 6; i++) begin
            bp_a[i] = {$urandom, $urandom};
            bp_b[i] = {$urandom, $urandom};
        end
        out_cnt = 0;
        idx     = 0;
        for (int c = 0; c < 6; c++) begin
            step(1'b1, bp_a[idx], bp_b[idx], 1'b0, 1'b0, 1'b0);
            if (acc_seen) idx++;
        end
        chk("bp_accepted", idx, NST);
        chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        held_s  = s;
        held_co = co;
        for (int c = 0; c < 2; c++) step(1'b1, bp_a[idx], bp_b[idx], 1'b0, 1'b0, 1'b0);
        chk("bp_still_full", idx, NST);
        chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_hold_s", s, held_s);
        chk("bp_hold_co", {63'd0, co}, {63'd0, held_co});
        for (int t = 0; t < 20 && idx < 6; t++) begin
            step(1'b1, bp_a[idx], bp_b[idx], 1'b0, 1'b0, 1'b1);
            if (acc_seen) idx++;
        end
        chk("bp_all_accepted", idx, 6);
        drain();
        chk("bp_outs", out_cnt, 6);

        // Subtraction with and without borrow.
        send(64'd5, 64'd7, 1'b1, 1'b1);
        send(64'd7, 64'd5, 1'b1, 1'b1);
        drain();

`ifdef CLA_PIPE_OVF_EN
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        send(64'd1, 64'd1, 1'b0, 1'b0);
        drain();
`endif

        // Reset with two beats in flight: discarded, nothing stale afterwards.
        send(64'h1234, 64'h5678, 1'b0, 1'b0);
        send(64'h1111, 64'h2222, 1'b0, 1'b0);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_s", s, 64'd0);
        chk("mid_rst_co", {63'd0, co}, 64'd0);
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        outs = 0;
        for (int i = 0; i < 8; i++) begin
            idle();
            if (ov_seen) outs++;
        end
        chk("post_rst_no_out", outs, 0);
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Pipe still works after the reset.
        send(64'd40, 64'd2, 1'b0, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cla_pipe.md
# cla_pipe

Parametrised, pipelined carry-lookahead adder/subtractor with a valid/ready handshake. It splits a WIDTH-bit operation into NSTAGE = WIDTH/SEG segments and resolves one segment per clock, with the inter-segment carry held in a register. It accepts one operation per cycle and is the wide arithmetic datapath of the factorial core. It replaces the fixed-width combinational adder chain wherever WIDTH makes a single-cycle carry path too long.

## Interface
Parameters:
- WIDTH, 64: operand and sum width. Must be a multiple of SEG.
- SEG, 16: segment width resolved per stage, using an internal SEG-bit lookahead adder. Derived value NSTAGE = WIDTH/SEG; NSTAGE ≥ 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts the beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- ci  in  1  carry-in; ignored when sub=1.
- sub  in  1  0: s = a+b+ci; 1: s = a−b, computed as a+~b+1.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- s  out  WIDTH  sum/difference, modulo 2^WIDTH.
- co  out  1  carry out of bit WIDTH−1. For subtraction, 1 means no borrow (a ≥ b unsigned).
- ovf  out  1  signed overflow; present only with CLA_PIPE_OVF_EN.

## Operation
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- At accept, the effective B (b, or ~b when sub=1) and the effective carry (ci, or 1 when sub=1) are latched into stage 0.
- Stage k (0..NSTAGE−1):
  - Adds segment k of A and effective B plus the registered carry from stage k−1 (stage 0 uses the effective carry).
  - Registers the segment-k sum and the carry.
  - Forwards the lower, already-resolved sum segments and the still-unresolved upper operand segments.
- Each stage holds one valid bit. A stage advances when its downstream is empty or is itself advancing. Bubbles collapse.
- Output register = last stage:
  - s is the concatenation of all segment sums.
  - co is the stage NSTAGE−1 carry.
- in_ready = !v0 || stage 0 advancing. This is combinational from out_ready through the valid chain; no other combinational input-to-output paths exist.
- While out_valid && !out_ready, the values of s, co and ovf must hold stable.
- Operations complete strictly in order; none are dropped or duplicated.
- NSTAGE=1 degenerates to a single registered stage.

## Timing
- Reset (reset_n low, effective immediately): all valid bits 0, all data and carry registers 0. Hence out_valid=0, s=0, co=0, ovf=0, and in_ready=1 after reset.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+NSTAGE−1, i.e. NSTAGE cycles from acceptance to first observable result with out_ready held 1.
- Throughput: 1 operation per cycle with out_ready=1.
- Backpressure: with out_ready=0 the pipeline fills. After NSTAGE further accepts, in_ready drops to 0 in the same cycle the last stage would overflow.
- Simultaneous accept and output transfer on a full pipeline: both occur, and occupancy is unchanged.
- Reset asserted mid-operation: in-flight operations are discarded and no out_valid is produced after release until a new accept.
- Wrap-around: a sum ≥ 2^WIDTH truncates to its low WIDTH bits, with co=1.

## Configuration
- CLA_PIPE_OVF_EN defined:
  - The ovf port exists.
  - ovf = carry into bit WIDTH−1 XOR co, registered with s and subject to the same reset and stall rules.
  - One extra carry bit is tracked in the last stage.
- Not defined: the ovf port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset: hold reset_n=0 mid-stream with 2 beats in flight → out_valid=0, s=0, co=0 immediately; after release no stale results appear and in_ready=1.
- Single add, WIDTH=64, SEG=16: a=0xFFFF_FFFF_FFFF_FFFF, b=0, ci=1 → after exactly 4 cycles s=0, co=1 (full cross-segment carry ripple).
- Back-to-back: 100 random beats with in_valid=1 and out_ready=1 → 100 results in order, one per cycle, matching a reference a+b+ci mod 2^64 with correct co.
- Backpressure: out_ready=0 while feeding 6 beats → exactly 4 accepted, in_ready=0 afterwards, outputs stable. Releasing out_ready drains all 4, then accepts the remaining 2 in order.
- Subtract: sub=1, a=5, b=7, ci=1 → s=0xFFFF_FFFF_FFFF_FFFE, co=0. Then a=7, b=5 → s=2, co=1.
- CLA_PIPE_OVF_EN: a=0x7FFF_FFFF_FFFF_FFFF, b=1, sub=0 → s=0x8000_0000_0000_0000, ovf=1, co=0. Then a=1, b=1 → ovf=0.
